// File: rtl/store_narrow_pkg.sv
// Shared types for the store narrowing path: size encodings, buffer states
// and the packed entry held in the output/skid registers.
package store_narrow_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'b00,
    BUF_ONE   = 2'b01,
    BUF_TWO   = 2'b10
  } buf_state_e;

  // Address field width of a buffered entry; store_narrow's ADDR_W must not exceed it.
  localparam int ENTRY_ADDR_W = 32;

  typedef struct packed {
    logic [ENTRY_ADDR_W-1:0] addr;
    logic [31:0]             wdata;
    logic [3:0]              be;
    logic                    err;
    logic                    ovf;
  } entry_t;

endpackage

// File: rtl/store_lane_align.sv
// Combinational store narrowing: lane-replicated write data, byte enables and
// alignment error. Overflow compare exists only with STORE_NARROW_OVF_CHECK_EN.
module store_lane_align
  import store_narrow_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic        err,
  output logic        ovf
);

  always_comb begin
    wdata = data;
    be    = 4'b0000;
    err   = 1'b0;
    case (size_e'(size))
      SZ_BYTE: begin
        wdata = {4{data[7:0]}};
        be    = 4'b0001 << addr_lo;
      end
      SZ_HALF: begin
        wdata = {2{data[15:0]}};
        if (addr_lo[0]) err = 1'b1;
        else            be  = 4'b0011 << addr_lo;
      end
      SZ_WORD: begin
        wdata = data;
        if (addr_lo != 2'b00) err = 1'b1;
        else                  be  = 4'b1111;
      end
      default: begin
        // Reserved size: still delivered so the next stage can trap on it.
        wdata = data;
        err   = 1'b1;
      end
    endcase
  end

`ifdef STORE_NARROW_OVF_CHECK_EN
  // Inverse of sign extension: discarded upper bits must replicate the kept sign bit.
  always_comb begin
    ovf = 1'b0;
    case (size_e'(size))
      SZ_BYTE: ovf = (data[31:8]  != {24{data[7]}});
      SZ_HALF: ovf = (data[31:16] != {16{data[15]}});
      default: ovf = 1'b0;
    endcase
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: rtl/store_narrow.sv
// Store narrowing stage with a 2-entry skid buffer between store issue and the
// data-memory write port. Optional overflow flag: STORE_NARROW_OVF_CHECK_EN.
module store_narrow
  import store_narrow_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_W-1:0]    in_addr,
  input  logic [31:0]          in_data,
  input  logic [1:0]           in_size,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ADDR_W-1:0]    out_addr,
  output logic [31:0]          out_wdata,
  output logic [3:0]           out_be,
  output logic                 out_err,
  output logic                 out_ovf,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (ADDR_W < 2 || ADDR_W > ENTRY_ADDR_W) begin : g_bad_addr_w
    $error("store_narrow: ADDR_W out of supported range");
  end

  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  buf_state_e state, state_n;
  entry_t     out_q, skid_q, new_entry;
  logic       in_ready_q;
  logic       accept, xfer;
  logic       load_out_new, load_out_skid, load_skid;

  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_err, al_ovf;

  store_lane_align u_align (
    .addr_lo (in_addr[1:0]),
    .size    (in_size),
    .data    (in_data),
    .wdata   (al_wdata),
    .be      (al_be),
    .err     (al_err),
    .ovf     (al_ovf)
  );

  // Narrowing happens before the buffer, so both registers hold final fields.
  always_comb begin
    new_entry.addr  = ENTRY_ADDR_W'(in_addr & WORD_MASK);
    new_entry.wdata = al_wdata;
    new_entry.be    = al_be;
    new_entry.err   = al_err;
    new_entry.ovf   = al_ovf;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid && in_ready_q;
  assign xfer      = out_valid && out_ready;

  always_comb begin
    state_n       = state;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          state_n      = BUF_ONE;
          load_out_new = 1'b1;
        end
      end
      BUF_ONE: begin
        if (accept && !xfer) begin
          state_n   = BUF_TWO;
          load_skid = 1'b1;
        end else if (accept && xfer) begin
          load_out_new = 1'b1;
        end else if (xfer) begin
          state_n = BUF_EMPTY;
        end
      end
      BUF_TWO: begin
        // in_ready is low here, so no accept can coincide with the drain.
        if (xfer) begin
          state_n       = BUF_ONE;
          load_out_skid = 1'b1;
        end
      end
      default: state_n = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BUF_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_n;
      in_ready_q <= (state_n != BUF_TWO);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_new)       out_q <= new_entry;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= new_entry;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (accept && new_entry.err && (err_cnt != '1)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  assign out_addr  = out_q.addr[ADDR_W-1:0];
  assign out_wdata = out_q.wdata;
  assign out_be    = out_q.be;
  assign out_err   = out_q.err;
  assign out_ovf   = out_q.ovf;

endmodule

// File: tb/tb_store_narrow.sv
// Directed self-checking bench for store_narrow (default 32-bit address, 8-bit
// error counter); expected overflow values follow STORE_NARROW_OVF_CHECK_EN.
module tb_store_narrow;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_data;
  logic [1:0]  in_size;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_wdata;
  logic [3:0]  out_be;
  logic        out_err;
  logic        out_ovf;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

`ifdef STORE_NARROW_OVF_CHECK_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  store_narrow #(.ADDR_W(32), .ERR_CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .in_size   (in_size),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_wdata (out_wdata),
    .out_be    (out_be),
    .out_err   (out_err),
    .out_ovf   (out_ovf),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    in_size  = s;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    drive(a, d, s);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] a, input logic [31:0] w,
                           input logic [3:0] be, input logic er);
    check({tag, "_valid"}, 64'(out_valid), 64'(1'b1));
    check({tag, "_addr"},  64'(out_addr),  64'(a));
    check({tag, "_wdata"}, 64'(out_wdata), 64'(w));
    check({tag, "_be"},    64'(out_be),    64'(be));
    check({tag, "_err"},   64'(out_err),   64'(er));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_addr   = '0;
    in_data   = '0;
    in_size   = 2'b00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  64'(in_ready),  64'(1'b1));
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_out_addr",  64'(out_addr),  64'(0));
    check("rst_out_wdata", 64'(out_wdata), 64'(0));
    check("rst_out_be",    64'(out_be),    64'(0));
    check("rst_out_err",   64'(out_err),   64'(0));
    check("rst_out_ovf",   64'(out_ovf),   64'(0));
    check("rst_err_cnt",   64'(err_cnt),   64'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Byte store into lane 3
    out_ready = 1'b1;
    send(32'h0000_1003, 32'h1234_5678, 2'b00);
    check_out("sb", 32'h0000_1000, 32'h7878_7878, 4'b1000, 1'b0);
    check("sb_ovf", 64'(out_ovf), 64'(1'b0));

    // Half stores, upper half: sign-consistent then overflowing
    send(32'h0000_2002, 32'hFFFF_8001, 2'b01);
    check_out("sh_a", 32'h0000_2000, 32'h8001_8001, 4'b1100, 1'b0);
    check("sh_a_ovf", 64'(out_ovf), 64'(1'b0));
    send(32'h0000_2002, 32'h0001_8001, 2'b01);
    check_out("sh_b", 32'h0000_2000, 32'h8001_8001, 4'b1100, 1'b0);
    check("sh_b_ovf", 64'(out_ovf), 64'(OVF_ON));

    // Byte overflow and aligned word
    send(32'h0000_3001, 32'h0000_0180, 2'b00);
    check_out("sb_ovf", 32'h0000_3000, 32'h8080_8080, 4'b0010, 1'b0);
    check("sb_ovf_flag", 64'(out_ovf), 64'(OVF_ON));
    send(32'h0000_3004, 32'hDEAD_BEEF, 2'b10);
    check_out("sw", 32'h0000_3004, 32'hDEAD_BEEF, 4'b1111, 1'b0);
    check("sw_ovf", 64'(out_ovf), 64'(1'b0));
    check("cnt_zero", 64'(err_cnt), 64'(0));

    // Misaligned half and word
    send(32'h0000_2001, 32'h1122_3344, 2'b01);
    check_out("sh_mis", 32'h0000_2000, 32'h3344_3344, 4'b0000, 1'b1);
    check("cnt_one", 64'(err_cnt), 64'(1));
    send(32'h0000_2006, 32'hCAFE_BABE, 2'b10);
    check_out("sw_mis", 32'h0000_2004, 32'hCAFE_BABE, 4'b0000, 1'b1);
    check("cnt_two", 64'(err_cnt), 64'(2));

    // 300 reserved-size requests back to back: counter saturates
    drive(32'h0000_0040, 32'h5555_AAAA, 2'b11);
    repeat (300) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("cnt_sat", 64'(err_cnt), 64'(255));
    check_out("rsvd", 32'h0000_0040, 32'h5555_AAAA, 4'b0000, 1'b1);
    @(posedge clk); #1;
    check("drain_empty", 64'(out_valid), 64'(1'b0));

    // Backpressure: A, B fill the buffer, C stalls
    out_ready = 1'b0;
    send(32'h0000_0100, 32'hAAAA_0001, 2'b10);
    check_out("bp_a0", 32'h0000_0100, 32'hAAAA_0001, 4'b1111, 1'b0);
    check("bp_rdy_one", 64'(in_ready), 64'(1'b1));
    send(32'h0000_0104, 32'hBBBB_0002, 2'b10);
    check("bp_rdy_two", 64'(in_ready), 64'(1'b0));
    check_out("bp_a1", 32'h0000_0100, 32'hAAAA_0001, 4'b1111, 1'b0);
    drive(32'h0000_0108, 32'hCCCC_0003, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    check("bp_rdy_stall", 64'(in_ready), 64'(1'b0));
    check_out("bp_a2", 32'h0000_0100, 32'hAAAA_0001, 4'b1111, 1'b0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_out("bp_b", 32'h0000_0104, 32'hBBBB_0002, 4'b1111, 1'b0);
    check("bp_rdy_back", 64'(in_ready), 64'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_out("bp_c", 32'h0000_0108, 32'hCCCC_0003, 4'b1111, 1'b0);
    @(posedge clk); #1;
    check("bp_empty", 64'(out_valid), 64'(1'b0));

    // Full throughput: accept and transfer every cycle
    for (int i = 0; i < 10; i++) begin
      drive(32'(i * 4), 32'h1000_0000 + 32'(i), 2'b10);
      @(posedge clk); #1;
      check("tp_wdata", 64'(out_wdata), 64'(32'h1000_0000 + 32'(i)));
      check("tp_addr",  64'(out_addr),  64'(i * 4));
      check("tp_rdy",   64'(in_ready),  64'(1'b1));
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("tp_empty", 64'(out_valid), 64'(1'b0));

    // Asynchronous reset while both entries are full
    out_ready = 1'b0;
    send(32'h0000_0201, 32'h0, 2'b10);
    send(32'h0000_0203, 32'h0, 2'b01);
    check("ar_two", 64'(in_ready), 64'(1'b0));
    check("ar_valid_pre", 64'(out_valid), 64'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 64'(out_valid), 64'(1'b0));
    check("ar_cnt",   64'(err_cnt),   64'(0));
    check("ar_rdy",   64'(in_ready),  64'(1'b1));
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("ar_no_stale", 64'(out_valid), 64'(1'b0));
    end
    check("ar_rdy_post", 64'(in_ready), 64'(1'b1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_narrow.md
Name: store_narrow

Overview:
- Store-side counterpart of the load-path sign extender. Narrows 32-bit register data to byte, halfword or word stores (SB/SH/SW).
- Generates lane-aligned write data and byte enables.
- Registered valid/ready handshake between the MEM-stage store issue and the data-memory write port, with a 2-entry skid buffer so backpressure never drops a store.

Parameters:
- ADDR_W, 32, address width in bits (minimum 2).
- ERR_CNT_W, 8, width of the saturating misalignment counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  store request valid.
- in_ready  out  1  block can accept a request this cycle.
- in_addr  in  ADDR_W  byte address.
- in_data  in  32  source register value.
- in_size  in  2  00=byte, 01=half, 10=word, 11=reserved.
- out_valid  out  1  memory request valid.
- out_ready  in  1  memory accepts request.
- out_addr  out  ADDR_W  word-aligned address (in_addr with [1:0] forced to 0).
- out_wdata  out  32  lane-replicated write data.
- out_be  out  4  byte enables, bit i = byte lane i (little-endian).
- out_err  out  1  misaligned or reserved-size request; out_be is 0.
- out_ovf  out  1  value does not fit the store width (optional feature).
- err_cnt  out  ERR_CNT_W  saturating count of accepted erroneous requests.

Behaviour:
- Reset values: in_ready=1 after reset release; out_valid=0; out_addr=0; out_wdata=0; out_be=0; out_err=0; out_ovf=0; err_cnt=0. Both buffer entries are invalidated. Asserting rst_n mid-operation discards any held requests immediately (asynchronous).
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Latency: an accepted request appears on the out_* outputs on the next cycle when the output register is free or being drained that cycle.
- Buffer states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: output register full, out_valid=1, in_ready=1.
  - TWO: output and skid full, out_valid=1, in_ready=0.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept and no transfer -> TWO; the request is written to skid.
  - ONE + transfer and no accept -> EMPTY.
  - ONE + both -> ONE; the new request moves into the output register.
  - TWO + transfer -> ONE; skid moves to the output register.
- in_ready is a registered signal; it depends only on skid occupancy, never combinationally on out_ready.
- Order is strictly FIFO. Outputs are stable while out_valid=1 and out_ready=0.
- Narrowing is computed at accept time; registers store the already-narrowed fields.
  - byte: wdata = {4{in_data[7:0]}}; be = 0001 << addr[1:0].
  - half: wdata = {2{in_data[15:0]}}; be = 0011 << addr[1:0]; requires addr[0]=0.
  - word: wdata = in_data; be = 1111; requires addr[1:0]=00.
  - Misaligned or size 11: be=0000, err=1, wdata as computed. The request is still delivered, so the downstream stage can raise an address exception.
- err_cnt increments by 1 on each accepted request with err=1 and saturates at all-ones (no wrap).

Optional Feature:
- Macro STORE_NARROW_OVF_CHECK_EN.
- Defined: out_ovf=1 when the upper bits discarded by narrowing are not a sign replication, which is the inverse check of sign extension.
  - byte: in_data[31:8] != {24{in_data[7]}}.
  - half: in_data[31:16] != {16{in_data[15]}}.
  - word: always 0.
  - The flag is registered alongside the data.
- Not defined: out_ovf is tied 0 and no compare logic is synthesized.
- All other behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11;
  - a packed struct for a buffered entry {addr, wdata, be, err, ovf}.
- One combinational sub-module, store_lane_align: takes addr[1:0], size and data; returns wdata, be, err, ovf.
- store_narrow instantiates store_lane_align once and implements the skid buffer and err_cnt.

Test Plan:
- Reset then byte store, addr=0x1003, data=0x12345678, out_ready=1 -> next cycle out_addr=0x1000, wdata=0x78787878, be=1000, err=0.
- Half store, addr=0x2002, data=0xFFFF8001 -> wdata=0x80018001, be=1100, err=0; with macro defined ovf=0. Repeat with data=0x00018001 -> ovf=1 (macro defined), ovf=0 (undefined).
- Misaligned half, addr=0x2001, then word at addr=0x2006 -> both delivered with be=0000, err=1; err_cnt=2. Force 300 errors with ERR_CNT_W=8 -> err_cnt holds 255.
- Backpressure: three back-to-back stores A,B,C with out_ready=0 -> A and B accepted; in_ready=0 the cycle after B; C stalls. Raise out_ready -> A,B,C emerge in order with no loss or duplication, and A is held stable while stalled.
- Simultaneous accept and transfer in ONE state for 10 cycles -> one request per cycle throughput, in_ready stays 1.
- Assert rst_n low asynchronously while in TWO state -> out_valid and err_cnt go 0 without a clock edge; after release in_ready=1 and no stale request appears.
